// File: rtl/load_store_unit.sv
// Sub-word load/store controller: turns byte/half/word requests into word-wide
// memory accesses (read-modify-write for SB/SH), big-endian lane ordering.
module load_store_unit #(
   parameter bit          ALIGN_CHECK    = 1'b1,
   parameter logic [31:0] RESET_LOADDATA = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        isStore,
   input  logic [2:0]  funct,
   input  logic [31:0] address,
   input  logic [31:0] storeData,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] loadData,
   output logic [31:0] memAddress,
   output logic [31:0] memWriteData,
   output logic        memRead,
   output logic        memWrite,
   input  logic [31:0] memReadData
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT_DATA, RESP} state_t;

   state_t      state, nextState;
   logic        latStore;
   logic [2:0]  latFunct;
   logic [31:0] latAddr;
   logic [31:0] latData;
   logic        errFlag;

   logic        legalFunct, storeBad, misaligned, illegal;
   logic [4:0]  byteShift, halfShift;
   logic [7:0]  byteLane;
   logic [15:0] halfLane;
   logic [31:0] extended;
   logic [31:0] mergedWord;

   // Request legality is judged on the live inputs in the accept cycle.
   assign legalFunct = funct inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
   assign storeBad   = isStore && funct[2];
   assign misaligned = ALIGN_CHECK &&
                       ((funct[1:0] == 2'b01 && address[0]) ||
                        (funct == 3'b011 && address[1:0] != 2'b00));
   assign illegal    = !legalFunct || storeBad || misaligned;

   // Big-endian: byte offset 0 is the most significant lane.
   assign byteShift = {~latAddr[1:0], 3'b000};
   assign halfShift = {~latAddr[1], 4'b0000};
   assign byteLane  = 8'(memReadData >> byteShift);
   assign halfLane  = 16'(memReadData >> halfShift);

   always_comb begin
      extended = memReadData;
      case (latFunct)
         3'b000:  extended = {{24{byteLane[7]}}, byteLane};
         3'b100:  extended = {24'h0, byteLane};
         3'b001:  extended = {{16{halfLane[15]}}, halfLane};
         3'b101:  extended = {16'h0, halfLane};
         default: extended = memReadData;
      endcase
   end

   always_comb begin
      if (latFunct == 3'b001)
         mergedWord = (memReadData & ~(32'h0000FFFF << halfShift)) |
                      ({16'h0, latData[15:0]} << halfShift);
      else
         mergedWord = (memReadData & ~(32'h000000FF << byteShift)) |
                      ({24'h0, latData[7:0]} << byteShift);
   end

   // State register plus the request latch and registered load result.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         latStore <= 1'b0;
         latFunct <= 3'b000;
         latAddr  <= 32'h0;
         latData  <= 32'h0;
         errFlag  <= 1'b0;
         loadData <= RESET_LOADDATA;
      end else begin
         state <= nextState;
         if (state == IDLE && req) begin
            latStore <= isStore;
            latFunct <= funct;
            latAddr  <= address;
            latData  <= storeData;
            errFlag  <= illegal;
         end
         if (state == WAIT_DATA && !latStore)
            loadData <= extended;
      end
   end

   // Next state and memory strobes; reset kills any strobe immediately.
   always_comb begin
      nextState    = state;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      memWriteData = latData;
      case (state)
         IDLE: begin
            if (req)
               nextState = illegal ? RESP : ACCESS;
         end
         ACCESS: begin
            if (latStore && latFunct == 3'b011) begin
               memWrite  = 1'b1;
               nextState = RESP;
            end else begin
               memRead   = 1'b1;
               nextState = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (latStore) begin
               memWrite     = 1'b1;
               memWriteData = mergedWord;
            end
            nextState = RESP;
         end
         RESP: nextState = IDLE;
         default: nextState = IDLE;
      endcase
      if (reset) begin
         memRead  = 1'b0;
         memWrite = 1'b0;
      end
   end

   assign busy       = (state != IDLE);
   assign done       = (state == RESP);
   assign error      = done && errFlag;
   assign memAddress = {latAddr[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model predicts the
// per-cycle output trace and memory contents; a negedge process compares.
module tb_load_store_unit;

   localparam bit ALIGN_CHECK = 1'b1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        isStore = 1'b0;
   logic [2:0]  funct = 3'b000;
   logic [31:0] address = 32'h0;
   logic [31:0] storeData = 32'h0;
   logic        busy, done, error, memRead, memWrite;
   logic [31:0] loadData, memAddress, memWriteData;
   logic [31:0] memReadData = 32'h0;

   load_store_unit #(.ALIGN_CHECK(ALIGN_CHECK), .RESET_LOADDATA(32'h0)) dut (
      .clock(clock), .reset(reset), .req(req), .isStore(isStore), .funct(funct),
      .address(address), .storeData(storeData), .busy(busy), .done(done),
      .error(error), .loadData(loadData), .memAddress(memAddress),
      .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite),
      .memReadData(memReadData)
   );

   always #5 clock = ~clock;

   // Synchronous-read data memory covering 0x7fff0000..0x7fff003f.
   logic [31:0] envMem [16];
   logic        preloadEn = 1'b0;
   logic [3:0]  preloadIdx = 4'h0;
   logic [31:0] preloadVal = 32'h0;

   always @(posedge clock) begin
      if (preloadEn) envMem[preloadIdx] <= preloadVal;
      else if (memWrite) envMem[memAddress[5:2]] <= memWriteData;
      if (memRead) memReadData <= envMem[memAddress[5:2]];
   end

   typedef struct packed {
      logic        busy, done, err, rd, wr;
      logic [31:0] addr, wdata, ld;
   } expRec_t;

   expRec_t     expQ[$];
   logic [31:0] refMem [16];
   logic [31:0] modelLd = 32'h0;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic expRec_t mk(input logic b, input logic dn, input logic er, input logic rd,
                                  input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                                  input logic [31:0] ld);
      expRec_t r;
      r.busy = b; r.done = dn; r.err = er; r.rd = rd; r.wr = wr;
      r.addr = ad; r.wdata = wd; r.ld = ld;
      return r;
   endfunction

   // One expected record per cycle, checked mid-cycle.
   always @(negedge clock) begin
      if (expQ.size() > 0) begin
         automatic expRec_t e = expQ.pop_front();
         checkOutput("busy", busy, e.busy);
         checkOutput("done", done, e.done);
         checkOutput("error", error, e.err);
         checkOutput("memRead", memRead, e.rd);
         checkOutput("memWrite", memWrite, e.wr);
         checkOutput("loadData", loadData, e.ld);
         if (e.rd || e.wr) checkOutput("memAddress", memAddress, e.addr);
         if (e.wr) checkOutput("memWriteData", memWriteData, e.wdata);
      end
   end

   task automatic applyIdle();
      expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0, modelLd));
      req = 1'b0;
      isStore = 1'($urandom); funct = 3'($urandom); address = $urandom; storeData = $urandom;
      @(posedge clock); #1;
   endtask

   // Model one request from the architectural rules, then drive it.
   task automatic applyStimulus(input logic st, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] d);
      logic [7:0]  b [4];
      logic [31:0] word, wa, newLd;
      logic [7:0]  v;
      logic [15:0] h;
      int          size, n, hi;
      logic        bad;
      word = refMem[a[5:2]];
      for (int k = 0; k < 4; k++) b[k] = word[31-8*k -: 8];
      size = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
      bad  = !(f inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101}) || (st && f[2]) ||
             (ALIGN_CHECK && ((a & 32'(size - 1)) != 32'h0));
      wa = {a[31:2], 2'b00};
      hi = a[1] ? 2 : 0;
      expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0, modelLd));
      if (bad) begin
         expQ.push_back(mk(1, 1, 1, 0, 0, 0, 0, modelLd));
         n = 1;
      end else if (st && size == 4) begin
         expQ.push_back(mk(1, 0, 0, 0, 1, wa, d, modelLd));
         expQ.push_back(mk(1, 1, 0, 0, 0, 0, 0, modelLd));
         refMem[a[5:2]] = d;
         n = 2;
      end else begin
         expQ.push_back(mk(1, 0, 0, 1, 0, wa, 0, modelLd));
         if (st) begin
            if (size == 1) b[a[1:0]] = d[7:0];
            else begin b[hi] = d[15:8]; b[hi+1] = d[7:0]; end
            word = {b[0], b[1], b[2], b[3]};
            refMem[a[5:2]] = word;
            expQ.push_back(mk(1, 0, 0, 0, 1, wa, word, modelLd));
         end else begin
            if (size == 1) begin
               v = b[a[1:0]];
               newLd = (f == 3'b000) ? {{24{v[7]}}, v} : {24'h0, v};
            end else if (size == 2) begin
               h = {b[hi], b[hi+1]};
               newLd = (f == 3'b001) ? {{16{h[15]}}, h} : {16'h0, h};
            end else newLd = word;
            expQ.push_back(mk(1, 0, 0, 0, 0, 0, 0, modelLd));
            modelLd = newLd;
         end
         expQ.push_back(mk(1, 1, 0, 0, 0, 0, 0, modelLd));
         n = 3;
      end
      req = 1'b1; isStore = st; funct = f; address = a; storeData = d;
      for (int c = 0; c <= n; c++) begin
         @(posedge clock); #1;
         req = (c < n) ? 1'($urandom) : 1'b0;
         isStore = 1'($urandom); funct = 3'($urandom); address = $urandom; storeData = $urandom;
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int firstRd, secondRd, rdCount;
      logic st;
      logic [2:0] f;
      logic [31:0] a;

      // Preload memory while reset is held.
      for (int i = 0; i < 16; i++) begin
         preloadEn = 1'b1; preloadIdx = 4'(i);
         preloadVal = (i == 4) ? 32'h8899AABB : $urandom;
         refMem[i] = preloadVal;
         @(posedge clock); #1;
      end
      preloadEn = 1'b0;
      @(negedge clock);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_loadData", loadData, 32'h0);
      checkOutput("rst_strobes", {memRead, memWrite}, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Directed cases with literal expectations.
      applyStimulus(0, 3'b000, 32'h7fff0011, 32'h0);
      checkOutput("lb_lit", loadData, 32'hFFFFFF99);
      applyStimulus(0, 3'b100, 32'h7fff0011, 32'h0);
      checkOutput("lbu_lit", loadData, 32'h00000099);
      applyStimulus(0, 3'b101, 32'h7fff0012, 32'h0);
      checkOutput("lhu_lit", loadData, 32'h0000AABB);
      applyStimulus(0, 3'b001, 32'h7fff0010, 32'h0);
      checkOutput("lh_lit", loadData, 32'hFFFF8899);
      applyStimulus(1, 3'b000, 32'h7fff0013, 32'h0000005C);
      checkOutput("sb_mem_lit", envMem[4], 32'h8899AA5C);
      applyStimulus(0, 3'b011, 32'h7fff0010, 32'h0);
      checkOutput("lw_lit", loadData, 32'h8899AA5C);
      applyStimulus(1, 3'b011, 32'h7fff0014, 32'h12345678);
      checkOutput("sw_mem_lit", envMem[5], 32'h12345678);
      applyStimulus(0, 3'b011, 32'h7fff0012, 32'h0);
      checkOutput("misalign_ld_lit", loadData, 32'h8899AA5C);
      applyStimulus(1, 3'b100, 32'h7fff0010, 32'hDEADBEEF);
      checkOutput("badstore_ld_lit", loadData, 32'h8899AA5C);
      checkOutput("badstore_mem_lit", envMem[4], 32'h8899AA5C);

      // SH abandoned by reset while waiting for read data.
      req = 1'b1; isStore = 1'b1; funct = 3'b001; address = 32'h7fff0018; storeData = $urandom;
      @(posedge clock); #1; req = 1'b0;
      @(negedge clock); checkOutput("abort_rd", memRead, 1);
      @(posedge clock); #1; reset = 1'b1;
      @(negedge clock); checkOutput("abort_wr", memWrite, 0);
      @(posedge clock); #1; reset = 1'b0;
      @(negedge clock);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_ld", loadData, 32'h0);
      checkOutput("abort_mem", envMem[6], refMem[6]);
      modelLd = 32'h0;
      @(posedge clock); #1;

      // req held high across two LW: reads must be 4 cycles apart.
      firstRd = -1; secondRd = -1; rdCount = 0;
      for (int i = 0; i < 10; i++) begin
         req = (i <= 4); isStore = 1'b0; funct = 3'b011; address = 32'h7fff0014;
         @(negedge clock);
         if (memRead) begin
            rdCount++;
            if (firstRd < 0) firstRd = i; else secondRd = i;
         end
         @(posedge clock); #1;
      end
      checkOutput("tput_count", rdCount, 2);
      checkOutput("tput_gap", secondRd - firstRd, 4);
      checkOutput("tput_ld", loadData, 32'h12345678);
      modelLd = 32'h12345678;

      // Randomized traffic.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) applyIdle();
         st = 1'($urandom);
         if ($urandom_range(0, 9) == 0) f = 3'($urandom);
         else case ($urandom_range(0, 4))
            0: f = 3'b000; 1: f = 3'b001; 2: f = 3'b011; 3: f = 3'b100; default: f = 3'b101;
         endcase
         a = 32'h7fff0000 | ($urandom & 32'h3f);
         if ($urandom_range(0, 3) != 0) begin
            if (f[1:0] == 2'b01) a[0] = 1'b0;
            if (f[1:0] == 2'b11) a[1:0] = 2'b00;
         end
         applyStimulus(st, f, a, $urandom);
      end
      applyIdle();
      @(posedge clock); #1;
      for (int i = 0; i < 16; i++) checkOutput("final_mem", envMem[i], refMem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
